// File: rtl/rx_serial_7n2_pkg.sv
// Shared definitions for the 7N2 serial receiver: state codes, baud timing
// defaults and frame geometry.
package rx_serial_7n2_pkg;

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    START   = 4'd1,
    DADOS   = 4'd2,
    STOP1   = 4'd3,
    STOP2   = 4'd4,
    FINAL   = 4'd5
  } estado_t;

  // Cycles per bit from a 50 MHz clock, with the counter width that holds M-1
  localparam int M_BAUD_9600   = 5208;
  localparam int N_BAUD_9600   = 13;
  localparam int M_BAUD_115200 = 434;
  localparam int N_BAUD_115200 = 9;

  localparam int DATA_BITS = 7;
  localparam int STOP_BITS = 2;

endpackage

// File: rtl/rx_serial_7n2_if.sv
// Serial line in, received character and debug signals out.
interface rx_serial_7n2_if;
  logic       dado_serial;
  logic [6:0] dados_ascii;
  logic       pronto;
  logic       erro;
  logic       db_dado_serial;
  logic       db_tick;
  logic [6:0] db_estado;

  modport master (
    output dado_serial,
    input  dados_ascii, pronto, erro, db_dado_serial, db_tick, db_estado
  );

  modport slave (
    input  dado_serial,
    output dados_ascii, pronto, erro, db_dado_serial, db_tick, db_estado
  );
endinterface

// File: rtl/contador_m.sv
// Modulo-M up counter with async and sync clear; fim at M-1, meio at M/2-1.
module contador_m #(
  parameter int M = 16,
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         zera_as,
  input  logic         zera_s,
  input  logic         conta,
  output logic [N-1:0] Q,
  output logic         fim,
  output logic         meio
);

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as)
      Q <= '0;
    else if (zera_s)
      Q <= '0;
    else if (conta) begin
      if (Q == N'(M - 1))
        Q <= '0;
      else
        Q <= Q + N'(1);
    end
  end

  assign fim  = (Q == N'(M - 1));
  assign meio = (Q == N'(M / 2 - 1));

endmodule

// File: rtl/hexa7seg.sv
// Hex digit to 7-segment pattern, active-low, bits [6:0] = g f e d c b a.
module hexa7seg (
  input  logic [3:0] hexa,
  output logic [6:0] display
);

  always_comb begin
    display = 7'b1111111;
    case (hexa)
      4'h0: display = 7'b1000000;
      4'h1: display = 7'b1111001;
      4'h2: display = 7'b0100100;
      4'h3: display = 7'b0110000;
      4'h4: display = 7'b0011001;
      4'h5: display = 7'b0010010;
      4'h6: display = 7'b0000010;
      4'h7: display = 7'b1111000;
      4'h8: display = 7'b0000000;
      4'h9: display = 7'b0010000;
      4'hA: display = 7'b0001000;
      4'hB: display = 7'b0000011;
      4'hC: display = 7'b1000110;
      4'hD: display = 7'b0100001;
      4'hE: display = 7'b0000110;
      4'hF: display = 7'b0001110;
      default: display = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/rx_serial_7n2_uc.sv
// Control FSM of the 7N2 receiver: start detection, bit sequencing, stop checks.
//   state   | meaning
//   INICIAL | idle, bit timer held at 0, waiting for a falling edge
//   START   | half-bit wait, confirm the start bit is still low
//   DADOS   | sample one data bit per strobe, 7 bits
//   STOP1   | sample first stop bit
//   STOP2   | sample second stop bit
//   FINAL   | one cycle: publish character and error, pulse pronto
module rx_serial_7n2_uc
  import rx_serial_7n2_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    borda,
  input  logic    linha,
  input  logic    tick_meio,
  input  logic    tick_fim,
  output estado_t estado,
  output logic    zera_cont,
  output logic    desloca,
  output logic    marca_erro,
  output logic    pronto,
  output logic    tick
);

  estado_t    prox;
  logic [2:0] n_bits, n_bits_prox;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= INICIAL;
      n_bits <= 3'd0;
    end else begin
      estado <= prox;
      n_bits <= n_bits_prox;
    end
  end

  always_comb begin
    prox        = estado;
    n_bits_prox = n_bits;
    zera_cont   = 1'b0;
    desloca     = 1'b0;
    marca_erro  = 1'b0;
    pronto      = 1'b0;
    tick        = 1'b0;
    case (estado)
      INICIAL: begin
        zera_cont = 1'b1;
        if (borda) begin
          n_bits_prox = 3'd0;
          prox        = START;
        end
      end
      START: begin
        // Zeroing at mid start bit puts every later strobe at mid-bit
        if (tick_meio) begin
          tick      = 1'b1;
          zera_cont = 1'b1;
          prox      = linha ? INICIAL : DADOS;
        end
      end
      DADOS: begin
        if (tick_fim) begin
          tick        = 1'b1;
          desloca     = 1'b1;
          n_bits_prox = n_bits + 3'd1;
          if (n_bits == 3'(DATA_BITS - 1))
            prox = STOP1;
        end
      end
      STOP1: begin
        if (tick_fim) begin
          tick       = 1'b1;
          marca_erro = ~linha;
          prox       = STOP2;
        end
      end
      STOP2: begin
        if (tick_fim) begin
          tick       = 1'b1;
          marca_erro = ~linha;
          prox       = FINAL;
        end
      end
      FINAL: begin
        pronto    = 1'b1;
        zera_cont = 1'b1;
        prox      = INICIAL;
      end
      default: prox = INICIAL;
    endcase
  end

endmodule

// File: rtl/rx_serial_7n2.sv
// 7N2 asynchronous serial receiver: synchronizer, bit timer, shift and
// output registers around the control FSM.
module rx_serial_7n2
  import rx_serial_7n2_pkg::*;
#(
  parameter int M_BAUD = M_BAUD_9600,
  parameter int N_BAUD = N_BAUD_9600
) (
  input  logic            clock,
  input  logic            reset,
  rx_serial_7n2_if.slave  bus
);

  logic              sync1, sync2, prev;
  logic              borda;
  logic [N_BAUD-1:0] cont;
  logic              fim, meio_unused;
  logic              tick_meio;
  estado_t           estado;
  logic              zera_cont, desloca, marca_erro, pronto, tick;
  logic [6:0]        shreg, dados;
  logic              err_flag, erro;
  logic [6:0]        seg;

  // Idle-high reset values keep a reset release from looking like a start edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= bus.dado_serial;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign borda = prev & ~sync2;

  contador_m #(.M(M_BAUD), .N(N_BAUD)) u_baud (
    .clock   (clock),
    .zera_as (reset),
    .zera_s  (zera_cont),
    .conta   (1'b1),
    .Q       (cont),
    .fim     (fim),
    .meio    (meio_unused)
  );

  assign tick_meio = (cont == N_BAUD'(M_BAUD / 2 - 1));

  rx_serial_7n2_uc u_uc (
    .clock      (clock),
    .reset      (reset),
    .borda      (borda),
    .linha      (sync2),
    .tick_meio  (tick_meio),
    .tick_fim   (fim),
    .estado     (estado),
    .zera_cont  (zera_cont),
    .desloca    (desloca),
    .marca_erro (marca_erro),
    .pronto     (pronto),
    .tick       (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      dados    <= '0;
      erro     <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      if (desloca)
        shreg <= {sync2, shreg[6:1]};
      if (pronto) begin
        dados    <= shreg;
        erro     <= err_flag;
        err_flag <= 1'b0;
      end else if (marca_erro) begin
        err_flag <= 1'b1;
      end
    end
  end

  hexa7seg u_hex (
    .hexa    (estado),
    .display (seg)
  );

  assign bus.dados_ascii    = dados;
  assign bus.pronto         = pronto;
  assign bus.erro           = erro;
  assign bus.db_dado_serial = sync2;
  assign bus.db_tick        = tick;
  assign bus.db_estado      = seg;

endmodule

// File: doc/rx_serial_7n2.md
Name: rx_serial_7N2

Overview:
Asynchronous serial receiver for the 7N2 link: 7 data bits, LSB first, no parity, 2 stop bits, 9600 baud from a 50 MHz clock. It is the receiving end of the team's 7N2 serial transmitter. It detects the start bit, samples each bit at mid-bit, assembles the character and presents it with a one-cycle completion pulse. It also flags framing errors and exposes the FSM state on a 7-segment debug output.

Parameters:
M_BAUD, 5208, clock cycles per bit (50 MHz / 9600); benches use 16.
N_BAUD, 13, width of the bit-timing counter (must hold M_BAUD-1).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; clears all state.
dado_serial  in  1  serial line; idles high.
dados_ascii  out  7  last received character; held until the next completed frame.
pronto  out  1  one-cycle pulse when a frame completes.
erro  out  1  framing error for the last frame; updated together with dados_ascii.
db_dado_serial  out  1  synchronized copy of dado_serial.
db_tick  out  1  sample-point strobe.
db_estado  out  7  FSM state code through hexa7seg.

Behaviour:
- Reset values: dados_ascii=0, pronto=0, erro=0, FSM=INICIAL, shift register=0, counters=0. Reset asserted mid-frame aborts the frame with no pronto.
- Line synchronizer: 2-FF on dado_serial; reset value 1. A previous-sample register (reset 1) is used for edge detection. All timing below counts from the synchronized line.
- States and 4-bit codes: INICIAL=0, START=1, DADOS=2, STOP1=3, STOP2=4, FINAL=5.
- INICIAL: waits for a 1->0 transition of the synced line.
  - A line held low (break, or after a framing error) does not retrigger; it must return high first.
  - On the edge: clear the bit counter, go to START.
- START: the strobe fires M_BAUD/2 cycles after the edge.
  - If the line is still 0 at the strobe: go to DADOS.
  - If the line is 1: false start, return to INICIAL with no outputs changed.
- DADOS: a strobe every M_BAUD cycles. Each strobe shifts the line into an internal 7-bit register, LSB first.
  - Go to STOP1 after the 7th bit.
- STOP1 / STOP2: sample at the next strobe.
  - Any 0 sets an internal error flag.
  - STOP2 always proceeds to FINAL.
- FINAL, one cycle:
  - dados_ascii <= shift register; erro <= error flag; pronto=1.
  - Clear the error flag, return to INICIAL.
- Latency: with the start edge at cycle t, the k-th strobe (k=0 start, 1..7 data, 8..9 stop) is at t + M_BAUD/2 + k*M_BAUD.
  - pronto is high in cycle t + M_BAUD/2 + 9*M_BAUD + 1.
  - The block is back in INICIAL during the second half of STOP2, so back-to-back frames are received.
- Framing error: the data is still delivered, with erro=1 and pronto pulsed.
- The bit counter wraps to 0 on each strobe. The strobe is held off (counter zeroed) in INICIAL.

Decomposition:
- Shared package holds the state encodings, M_BAUD/N_BAUD defaults for 9600 and 115200 (434/9), DATA_BITS=7 and STOP_BITS=2.
- Bit timing reuses the existing contador_m; its meio output is not used, and the half-bit preload is done in the FSM by zeroing at M_BAUD/2.
- One new sub-module is natural: rx_serial_uc, the control FSM. The shift and output registers stay in the top.
- db_estado reuses hexa7seg.

Test Plan (M_BAUD=16):
- Frame for 'A' (0x41: start 0, bits 1,0,0,0,0,0,1, stop 1,1) -> pronto pulses once 153 cycles after the start edge (+2 synchronizer); dados_ascii=0x41, erro=0.
- Back-to-back 0x55 then 0x2A with no idle gap -> two pronto pulses 160 cycles apart; values 0x55 then 0x2A; erro=0 for both.
- Line low for 4 cycles then high (glitch) -> FSM returns to INICIAL; no pronto; dados_ascii unchanged.
- 0x7F frame with STOP2=0 -> pronto=1, dados_ascii=0x7F, erro=1. Line then held low 50 cycles -> no new frame until the line rises and falls again.
- Reset asserted at data bit 3 of a 0x33 frame -> outputs 0 immediately (asynchronous); no pronto. The next clean 0x33 frame is received correctly.
- db_estado walks 0,1,2,3,4,5,0 through a frame, showing hexa7seg codes.
